seq_detect_fsm: RTL and testbench

- Parametrised Mealy sequence detector for serial input X; generalises the team's fixed 4-state X/Y FSM to any pattern width and pattern value.
- Supports overlapping or non-overlapping detection, a clock-enable, a registered copy of the match output, and a saturating match counter.
- Sits on a serial bit stream feeding status/interrupt logic. One clock domain.

---
 rtl/seq_detect_fsm_if.sv | 27 ++
 rtl/seq_detect_fsm.sv | 108 ++++++++++
 tb/tb_seq_detect_fsm.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_fsm_if.sv
// Serial-bit and match-status bundle for seq_detect_fsm.
// The state width tracks PAT_W the same way the detector does.
interface seq_detect_fsm_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  localparam int SW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic             en;
  logic             clear;
  logic             X;
  logic             Y;
  logic             Y_q;
  logic [SW-1:0]    state;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output en, clear, X,
    input  Y, Y_q, state, match_count, count_sat
  );

  modport slave (
    input  en, clear, X,
    output Y, Y_q, state, match_count, count_sat
  );
endinterface

// File: rtl/seq_detect_fsm.sv
// Parametrised Mealy sequence detector with KMP fallback, built from
// elaboration-time transition tables, plus a registered match flag and saturating counter.
module seq_detect_fsm #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  seq_detect_fsm_if.slave bus
);
  localparam int SW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int NS = 2 ** SW;

  typedef logic [SW-1:0] state_t;

  function automatic logic pat_bit(input int i);
    return 1'(PATTERN >> i);
  endfunction

  // Longest suffix of (prefix of length s, then x) that is a proper prefix of PATTERN.
  // A full match falls back to the longest border, or to 0 without overlap.
  function automatic int kmp_next(input int s, input logic x);
    int   kmax;
    int   p;
    logic ok;
    logic b;
    if (s >= PAT_W) return 0;
    if ((s == PAT_W - 1) && (x == pat_bit(0)) && (OVERLAP == 0)) return 0;
    kmax = (s + 1 < PAT_W - 1) ? s + 1 : PAT_W - 1;
    for (int k = kmax; k > 0; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        p = s + 1 - k + j;
        b = (p == s) ? x : pat_bit(PAT_W - 1 - p);
        if (b != pat_bit(PAT_W - 1 - j)) ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  state_t w_next_tbl [NS][2];

  // Codes at or beyond PAT_W are unreachable; they map back to 0.
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_tbl
      localparam state_t N0 = state_t'(kmp_next(gi, 1'b0));
      localparam state_t N1 = state_t'(kmp_next(gi, 1'b1));
      assign w_next_tbl[gi][0] = N0;
      assign w_next_tbl[gi][1] = N1;
    end
  endgenerate

  state_t           r_state;
  logic             r_yq;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  state_t           w_state_next;
  logic             w_yq_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_sat_next;
  logic             w_y;

  assign w_y = bus.en & ~bus.clear & (r_state == state_t'(PAT_W - 1)) & (bus.X == pat_bit(0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= '0;
      r_yq    <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_yq    <= w_yq_next;
      r_cnt   <= w_cnt_next;
      r_sat   <= w_sat_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_yq_next    = 1'b0;
    w_cnt_next   = r_cnt;
    w_sat_next   = r_sat;
    if (bus.clear) begin
      w_state_next = '0;
      w_cnt_next   = '0;
      w_sat_next   = 1'b0;
    end else if (bus.en) begin
      w_state_next = w_next_tbl[r_state][bus.X];
      w_yq_next    = w_y;
      if (w_y && !r_sat) begin
        w_cnt_next = r_cnt + CNT_W'(1);
        w_sat_next = &w_cnt_next;
      end
    end
  end

  assign bus.Y           = w_y;
  assign bus.Y_q         = r_yq;
  assign bus.state       = r_state;
  assign bus.match_count = r_cnt;
  assign bus.count_sat   = r_sat;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: an overlapping 8-bit-counter instance (A) and a
// non-overlapping 2-bit-counter instance (B) driven in lockstep against a bit-history model.
module tb_seq_detect_fsm;
  localparam int PW = 4;
  localparam logic [PW-1:0] PAT = 4'b1011;

  logic clk;
  logic reset;

  seq_detect_fsm_if #(.PAT_W(PW), .CNT_W(8)) ifa ();
  seq_detect_fsm_if #(.PAT_W(PW), .CNT_W(2)) ifb ();

  seq_detect_fsm #(.PAT_W(PW), .PATTERN(PAT), .OVERLAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  seq_detect_fsm #(.PAT_W(PW), .PATTERN(PAT), .OVERLAP(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [PW-1:0] pat_v;

  // Reference model: raw accepted bits since the last restart, per instance.
  bit hist_q [2][$];
  int cnt_m  [2];
  bit yq_m   [2];
  int cmax   [2];
  bit ovl    [2];
  bit last_y [2];

  typedef struct {
    bit en; bit clr; bit x;
    int ya; int sa; int yb; int sb;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (txn %0d)", name, act, exp, txn);
    end
  endtask

  function automatic bit pbit(input int i);
    return 1'(pat_v >> i);
  endfunction

  function automatic bit full_match(input bit h[$]);
    int n = h.size();
    if (n < PW) return 1'b0;
    for (int j = 0; j < PW; j++)
      if (h[n - PW + j] != pbit(PW - 1 - j)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int suffix_state(input bit h[$]);
    int n = h.size();
    int kmax = (n < PW - 1) ? n : PW - 1;
    bit ok;
    for (int k = kmax; k > 0; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (h[n - k + j] != pbit(PW - 1 - j)) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      hist_q[m].delete();
      cnt_m[m] = 0;
      yq_m[m]  = 1'b0;
    end
  endtask

  task automatic check_regs();
    chk("A.state", int'(ifa.state), suffix_state(hist_q[0]));
    chk("B.state", int'(ifb.state), suffix_state(hist_q[1]));
    chk("A.Y_q", int'(ifa.Y_q), int'(yq_m[0]));
    chk("B.Y_q", int'(ifb.Y_q), int'(yq_m[1]));
    chk("A.count", int'(ifa.match_count), cnt_m[0]);
    chk("B.count", int'(ifb.match_count), cnt_m[1]);
    chk("A.sat", int'(ifa.count_sat), int'(cnt_m[0] == cmax[0]));
    chk("B.sat", int'(ifb.count_sat), int'(cnt_m[1] == cmax[1]));
  endtask

  task automatic step(input bit e, input bit c, input bit x);
    bit tmp[$];
    bit yp[2];
    @(negedge clk);
    ifa.en = e; ifa.clear = c; ifa.X = x;
    ifb.en = e; ifb.clear = c; ifb.X = x;
    #1;
    for (int m = 0; m < 2; m++) begin
      yp[m] = 1'b0;
      if (e && !c) begin
        tmp = hist_q[m];
        tmp.push_back(x);
        yp[m] = full_match(tmp);
      end
      last_y[m] = yp[m];
    end
    chk("A.Y", int'(ifa.Y), int'(yp[0]));
    chk("B.Y", int'(ifb.Y), int'(yp[1]));
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (c) begin
        hist_q[m].delete();
        cnt_m[m] = 0;
        yq_m[m]  = 1'b0;
      end else if (e) begin
        hist_q[m].push_back(x);
        if (yp[m]) begin
          if (!ovl[m]) hist_q[m].delete();
          if (cnt_m[m] < cmax[m]) cnt_m[m]++;
        end
        while (hist_q[m].size() > PW) void'(hist_q[m].pop_front());
        yq_m[m] = yp[m];
      end else begin
        yq_m[m] = 1'b0;
      end
    end
    check_regs();
    txn++;
    $display("txn %0d en=%0b clr=%0b x=%0b | A y=%0b st=%0d yq=%0b cnt=%0d sat=%0b | B y=%0b st=%0d yq=%0b cnt=%0d sat=%0b",
             txn, e, c, x, last_y[0], ifa.state, ifa.Y_q, ifa.match_count, ifa.count_sat,
             last_y[1], ifb.state, ifb.Y_q, ifb.match_count, ifb.count_sat);
  endtask

  task automatic add(input bit e, input bit c, input bit x,
                     input int ya, input int sa, input int yb, input int sb);
    vec_t v;
    v.en = e; v.clr = c; v.x = x;
    v.ya = ya; v.sa = sa; v.yb = yb; v.sb = sb;
    vecs.push_back(v);
  endtask

  task automatic feed_pattern();
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  int exp_cnt_b [4];
  int exp_sat_b [4];

  initial begin
    pat_v = PAT;
    cmax[0] = 255; cmax[1] = 3;
    ovl[0]  = 1'b1; ovl[1] = 1'b0;
    exp_cnt_b = '{1, 2, 3, 3};
    exp_sat_b = '{0, 0, 1, 1};
    model_reset();

    ifa.en = 0; ifa.clear = 0; ifa.X = 0;
    ifb.en = 0; ifb.clear = 0; ifb.X = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_regs();
    chk("A.Y.reset", int'(ifa.Y), 0);
    chk("B.Y.reset", int'(ifb.Y), 0);
    @(negedge clk);
    reset = 1'b1;

    // {en, clear, X} -> Y and state afterwards for A (overlap) and B (no overlap)
    add(1, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 1); add(1, 0, 0, 0, 2, 0, 2); add(1, 0, 1, 0, 3, 0, 3);
    add(1, 0, 1, 1, 1, 1, 0); add(1, 0, 0, 0, 2, 0, 0); add(1, 0, 1, 0, 3, 0, 1);
    add(1, 0, 1, 1, 1, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 1); add(1, 0, 1, 0, 1, 0, 1); add(1, 0, 0, 0, 2, 0, 2);
    add(1, 0, 1, 0, 3, 0, 3); add(1, 0, 1, 1, 1, 1, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 0, 1); add(1, 0, 0, 0, 2, 0, 2); add(1, 0, 1, 0, 3, 0, 3);
    add(0, 0, 0, 0, 3, 0, 3); add(0, 0, 0, 0, 3, 0, 3); add(0, 0, 0, 0, 3, 0, 3);
    add(1, 0, 1, 1, 1, 1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].x);
      chk("tbl.A.Y", int'(last_y[0]), vecs[i].ya);
      chk("tbl.B.Y", int'(last_y[1]), vecs[i].yb);
      chk("tbl.A.state", int'(ifa.state), vecs[i].sa);
      chk("tbl.B.state", int'(ifb.state), vecs[i].sb);
    end

    // Saturation of the 2-bit counter on B, then clear
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      feed_pattern();
      chk("sat.B.count", int'(ifb.match_count), exp_cnt_b[i]);
      chk("sat.B.sat", int'(ifb.count_sat), exp_sat_b[i]);
    end
    step(1, 1, 0);
    chk("clr.B.count", int'(ifb.match_count), 0);
    chk("clr.B.sat", int'(ifb.count_sat), 0);
    chk("clr.B.state", int'(ifb.state), 0);

    // Asynchronous reset in the middle of a partial match
    feed_pattern();
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    chk("pre.A.state", int'(ifa.state), 3);
    chk("pre.A.count", int'(ifa.match_count), 1);
    #2;
    ifa.en = 0; ifb.en = 0;
    reset = 1'b0;
    #1;
    model_reset();
    chk("arst.A.state", int'(ifa.state), 0);
    chk("arst.B.state", int'(ifb.state), 0);
    chk("arst.A.count", int'(ifa.match_count), 0);
    chk("arst.A.Y_q", int'(ifa.Y_q), 0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 0, 1);
    chk("post.A.Y", int'(last_y[0]), 0);
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
    chk("post.A.Y", int'(last_y[0]), 1);
    chk("post.B.Y", int'(last_y[1]), 1);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
